// File: rtl/fp32_pkg.sv
// Shared single-precision constants, FSM states and operand classes
// for the sequential square-root unit.
package fp32_pkg;

    localparam int BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        CALC,
        ROUND,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_ZERO,
        OP_SUBN,
        OP_NORM,
        OP_INF,
        OP_NAN
    } op_class_t;

    function automatic op_class_t classify(input logic [31:0] x);
        if (x[30:23] == 8'hFF)
            return (x[22:0] != '0) ? OP_NAN : OP_INF;
        if (x[30:23] == 8'h00)
            return (x[22:0] != '0) ? OP_SUBN : OP_ZERO;
        return OP_NORM;
    endfunction

    function automatic logic [4:0] clz23(input logic [22:0] f);
        logic [4:0] cnt;
        logic found;
        cnt = '0;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found) begin
                if (f[i]) found = 1'b1;
                else cnt = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

    // 1.f for odd biased exponents, 2*(1.f) for even ones
    function automatic logic [49:0] make_rad(input logic [23:0] sig,
                                             input logic odd);
        return odd ? {1'b0, sig, 25'b0} : {sig, 26'b0};
    endfunction

endpackage

// File: rtl/fpsqrt_step.sv
// One restoring square-root iteration: brings in two radicand bits
// and decides the next root bit.
module fpsqrt_step (
    input  logic [26:0] rem,
    input  logic [24:0] root,
    input  logic [1:0]  bits,
    output logic [26:0] rem_next,
    output logic        root_bit
);

    logic [26:0] shifted;
    logic [26:0] trial;

    assign shifted  = {rem[24:0], bits};
    assign trial    = {root, 2'b01};
    assign root_bit = (rem[26:25] != 2'b00) || (shifted >= trial);
    assign rem_next = root_bit ? (shifted - trial) : shifted;

endmodule

// File: rtl/fpsqrt_32b_seq.sv
// Iterative IEEE-754 single-precision square root, one root bit per cycle.
// Define FPSQRT_SUBNORMAL_EN to normalise subnormal inputs instead of flushing.
module fpsqrt_32b_seq
    import fp32_pkg::*;
#(
    parameter int m = 8,
    parameter int n = 23
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [m+n:0]   a_in,
    output logic           busy,
    output logic           done,
    output logic [m+n:0]   c_out,
    output logic           invalid
);

    state_t state;
    op_class_t cls;
    logic [49:0] rad;
    logic [26:0] rem;
    logic [26:0] rem_nx;
    logic [24:0] root;
    logic        rbit;
    logic [4:0]  cnt;
    logic [7:0]  res_exp;
    logic [31:0] res;
    logic        res_inv;
    logic        spec_hit;
    logic        spec_inv;
    logic [31:0] spec_val;
    logic        neg_nz;
    logic        zero_like;

    fpsqrt_step u_step (
        .rem      (rem),
        .root     (root),
        .bits     (rad[49:48]),
        .rem_next (rem_nx),
        .root_bit (rbit)
    );

    assign cls = classify(a_in);

`ifdef FPSQRT_SUBNORMAL_EN
    logic [22:0] sub_frac;
    logic [4:0]  norm_sh;
    logic [23:0] norm_sig;
    logic [7:0]  norm_t;

    // norm_t = effective exponent + 127; its parity picks the radicand scale
    assign norm_sh   = clz23(sub_frac) + 5'd1;
    assign norm_sig  = {1'b0, sub_frac} << norm_sh;
    assign norm_t    = 8'd128 - {3'b0, norm_sh};
    assign neg_nz    = a_in[31] && (cls != OP_ZERO);
    assign zero_like = (cls == OP_ZERO);
`else
    assign neg_nz    = a_in[31] && (cls != OP_ZERO) && (cls != OP_SUBN);
    assign zero_like = (cls == OP_ZERO) || (cls == OP_SUBN);
`endif

    always_comb begin
        spec_hit = 1'b1;
        spec_inv = 1'b0;
        spec_val = QNAN;
        if (cls == OP_NAN) begin
            spec_val = QNAN;
        end else if (neg_nz) begin
            spec_inv = 1'b1;
        end else if (zero_like) begin
            spec_val = {a_in[31], 31'b0};
        end else if (cls == OP_INF) begin
            spec_val = POS_INF;
        end else begin
            spec_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            c_out   <= '0;
            invalid <= 1'b0;
            cnt     <= '0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            res_exp <= '0;
            res     <= '0;
            res_inv <= 1'b0;
`ifdef FPSQRT_SUBNORMAL_EN
            sub_frac <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= start;
                    if (start) begin
                        rem  <= '0;
                        root <= '0;
                        cnt  <= 5'd24;
                        if (spec_hit) begin
                            res     <= spec_val;
                            res_inv <= spec_inv;
                            state   <= DONE;
`ifdef FPSQRT_SUBNORMAL_EN
                        end else if (cls == OP_SUBN) begin
                            sub_frac <= a_in[22:0];
                            state    <= NORM;
`endif
                        end else begin
                            rad     <= make_rad({1'b1, a_in[22:0]}, a_in[23]);
                            res_exp <= {1'b0, a_in[30:24]}
                                     + (a_in[23] ? 8'd64 : 8'd63);
                            res_inv <= 1'b0;
                            state   <= CALC;
                        end
                    end
                end
`ifdef FPSQRT_SUBNORMAL_EN
                NORM: begin
                    rad     <= make_rad(norm_sig, ~norm_t[0]);
                    res_exp <= {1'b0, norm_t[7:1]};
                    res_inv <= 1'b0;
                    state   <= CALC;
                end
`endif
                CALC: begin
                    rem  <= rem_nx;
                    root <= {root[23:0], rbit};
                    rad  <= {rad[47:0], 2'b00};
                    if (cnt == 5'd0) state <= ROUND;
                    else cnt <= cnt - 5'd1;
                end
                ROUND: begin
                    // root[24] is always set; all-ones rounds up into the exponent
                    res <= {1'b0,
                            res_exp + {7'b0, &root[23:0]},
                            root[23:1] + {22'b0, root[0]}};
                    state <= DONE;
                end
                DONE: begin
                    c_out   <= res;
                    invalid <= res_inv;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpsqrt_32b_seq.sv
// Self-checking bench for fpsqrt_32b_seq: scoreboard of expected
// results, latencies and handshake behaviour.
module tb_fpsqrt_32b_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic        busy;
    logic        done;
    logic [31:0] c_out;
    logic        invalid;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] c;
        logic        inv;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fpsqrt_32b_seq #(.m(8), .n(23)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .busy    (busy),
        .done    (done),
        .c_out   (c_out),
        .invalid (invalid)
    );

    // Drive one start pulse; returns 1 ns after the accept edge (edge 0).
    task automatic issue(input logic [31:0] a, input logic [31:0] c,
                         input logic inv, input int lat);
        exp_t e;
        e.a = a; e.c = c; e.inv = inv; e.lat = lat;
        @(negedge clk);
        a_in = a;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for done; lat is the edge number after which done was seen.
    task automatic wait_done(input int base, output logic [31:0] c,
                             output logic inv, output int lat,
                             output bit got);
        got = 1'b0; lat = -1; c = '0; inv = 1'b0;
        for (int k = base; k < base + 100 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; lat = k; c = c_out; inv = invalid;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (c_out !== 32'h0) begin
            n_fail++; $display("FAIL reset_c_out got=%h want=%h", c_out, 32'h0);
        end
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done got=%b want=0", done);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        n_checks++;
        if (invalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_invalid got=%b want=0", invalid);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic run_table(input string tag, input logic [31:0] ops[],
                             input logic [31:0] res[], input logic invs[],
                             input int lats[]);
        logic [31:0] c;
        logic inv;
        int lat;
        bit got;
        exp_t e;
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i], res[i], invs[i], lats[i]);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL %s_busy a=%h got=%b want=1", tag, ops[i], busy);
            end
            wait_done(0, c, inv, lat, got);
            e = sb.pop_front();
            n_checks++;
            if (!got) begin
                n_fail++; $display("FAIL %s_timeout a=%h no done", tag, e.a);
                continue;
            end
            if (c !== e.c) begin
                n_fail++; $display("FAIL %s_value a=%h got=%h want=%h", tag, e.a, c, e.c);
            end
            n_checks++;
            if (inv !== e.inv) begin
                n_fail++; $display("FAIL %s_invalid a=%h got=%b want=%b", tag, e.a, inv, e.inv);
            end
            n_checks++;
            if (lat !== e.lat) begin
                n_fail++; $display("FAIL %s_latency a=%h got=%0d want=%0d", tag, e.a, lat, e.lat);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL %s_busy_done a=%h got=%b want=1", tag, e.a, busy);
            end
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++; $display("FAIL %s_idle a=%h got busy=%b done=%b want 0 0",
                                   tag, e.a, busy, done);
            end
        end
    endtask

    task automatic test_normal();
        logic [31:0] ops[] = '{32'h40800000, 32'h41C80000, 32'h40000000,
                               32'h3F800000, 32'h41800000, 32'h3E800000,
                               32'h41100000};
        logic [31:0] res[] = '{32'h40000000, 32'h40A00000, 32'h3FB504F3,
                               32'h3F800000, 32'h40800000, 32'h3F000000,
                               32'h40400000};
        logic invs[] = '{0, 0, 0, 0, 0, 0, 0};
        int lats[] = '{27, 27, 27, 27, 27, 27, 27};
        run_table("normal", ops, res, invs, lats);
    endtask

    task automatic test_specials();
        logic [31:0] ops[] = '{32'hBF800000, 32'h80000000, 32'h7F800000,
                               32'h00000000, 32'h7FC00001, 32'hFF800000,
                               32'hFFC00000};
        logic [31:0] res[] = '{32'h7FC00000, 32'h80000000, 32'h7F800000,
                               32'h00000000, 32'h7FC00000, 32'h7FC00000,
                               32'h7FC00000};
        logic invs[] = '{1, 0, 0, 0, 0, 1, 0};
        int lats[] = '{1, 1, 1, 1, 1, 1, 1};
        run_table("special", ops, res, invs, lats);
    endtask

    task automatic test_subnormal();
`ifdef FPSQRT_SUBNORMAL_EN
        logic [31:0] ops[] = '{32'h00000001, 32'h80000001};
        logic [31:0] res[] = '{32'h1A3504F3, 32'h7FC00000};
        logic invs[] = '{0, 1};
        int lats[] = '{28, 1};
`else
        logic [31:0] ops[] = '{32'h00000001, 32'h80000001};
        logic [31:0] res[] = '{32'h00000000, 32'h80000000};
        logic invs[] = '{0, 0};
        int lats[] = '{1, 1};
`endif
        run_table("subnormal", ops, res, invs, lats);
    endtask

    task automatic test_ignore_busy();
        logic [31:0] c;
        logic inv;
        int lat;
        int extra;
        bit got;
        exp_t e;
        issue(32'h40800000, 32'h40000000, 1'b0, 27);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a_in = 32'h41C80000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(5, c, inv, lat, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || c !== e.c || lat !== e.lat) begin
            n_fail++; $display("FAIL ignore_first got=%h lat=%0d want=%h lat=%0d",
                               c, lat, e.c, e.lat);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++; $display("FAIL ignore_extra_done got=%0d want=0", extra);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] c;
        logic inv;
        int lat;
        int extra;
        bit got;
        exp_t e;
        issue(32'h40000000, 32'h3FB504F3, 1'b0, 27);
        void'(sb.pop_back());
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (c_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || invalid !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs got c=%h busy=%b done=%b inv=%b want all 0",
                               c_out, busy, done, invalid);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_checks++;
        if (extra != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_done got=%0d busy=%b want 0 0", extra, busy);
        end
        issue(32'h41C80000, 32'h40A00000, 1'b0, 27);
        wait_done(0, c, inv, lat, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || c !== e.c || inv !== e.inv || lat !== e.lat) begin
            n_fail++; $display("FAIL abort_recover got=%h inv=%b lat=%0d want=%h inv=%b lat=%0d",
                               c, inv, lat, e.c, e.inv, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c;
        logic inv;
        int lat;
        bit got;
        exp_t e;
        exp_t e2;
        e.a = 32'h3F800000; e.c = 32'h3F800000; e.inv = 1'b0; e.lat = 27;
        e2.a = 32'h3F800000; e2.c = 32'h3F800000; e2.inv = 1'b0; e2.lat = 27;
        @(negedge clk);
        a_in = 32'h3F800000;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        wait_done(0, c, inv, lat, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || c !== e.c || lat !== e.lat) begin
            n_fail++; $display("FAIL b2b_first got=%h lat=%0d want=%h lat=%0d",
                               c, lat, e.c, e.lat);
        end
        sb.push_back(e2);
        @(posedge clk);
        #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_reaccept busy got=%b want=1", busy);
        end
        wait_done(0, c, inv, lat, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || c !== e.c || lat !== e.lat) begin
            n_fail++; $display("FAIL b2b_second got=%h lat=%0d want=%h lat=%0d",
                               c, lat, e.c, e.lat);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_specials();
        test_subnormal();
        test_ignore_busy();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
